// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and ID-stage sequencer types.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } id_state_t;

    // What the IF/ID register does this cycle.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_SQUASH  = 2'd3
    } id_act_t;

endpackage

// File: rtl/rs_use_decode.sv
// Opcode -> source-register usage; shared by hazard detection and forwarding.
module rs_use_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // Classify the opcode by which source register fields are real operands.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b0;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: IF/ID register, load-use stall, redirect squash and
// saturating stall/flush counters.
module id_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ext_stall,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [PC_W-1:0]  id_pc,
    output logic             pc_write,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    id_state_t state_r;
    id_state_t next_state_s;
    id_act_t   act_s;
    logic      uses_rs1_s;
    logic      uses_rs2_s;
    logic      hazard_s;

    rs_use_decode u_rs_use_decode (
        .opcode   (id_inst[6:0]),
        .uses_rs1 (uses_rs1_s),
        .uses_rs2 (uses_rs2_s)
    );

    assign hazard_s = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((uses_rs1_s & (id_inst[19:15] == ex_rd)) |
                       (uses_rs2_s & (id_inst[24:20] == ex_rd)));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: redirect beats a freeze, which beats the hazard check.
    always_comb begin
        next_state_s = state_r;
        if (ex_redirect) begin
            next_state_s = FLUSH;
        end else if (ext_stall) begin
            next_state_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s) begin
                        next_state_s = LU_STALL;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                LU_STALL: next_state_s = RUN;
                FLUSH:    next_state_s = RUN;
                default:  next_state_s = RUN;
            endcase
        end
    end

    // Outputs: fetch enable, bubble request and the ID register action.
    always_comb begin
        act_s     = ACT_ADVANCE;
        pc_write  = 1'b1;
        id_bubble = 1'b0;
        if (ex_redirect) begin
            act_s     = ACT_SQUASH;
            pc_write  = 1'b1;
            id_bubble = 1'b1;
        end else if (ext_stall) begin
            act_s     = ACT_HOLD;
            pc_write  = 1'b0;
            id_bubble = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s) begin
                        act_s     = ACT_STALL;
                        pc_write  = 1'b0;
                        id_bubble = 1'b1;
                    end else begin
                        act_s     = ACT_ADVANCE;
                        pc_write  = 1'b1;
                        id_bubble = 1'b0;
                    end
                end
                LU_STALL: begin
                    act_s     = ACT_ADVANCE;
                    pc_write  = 1'b1;
                    id_bubble = 1'b0;
                end
                FLUSH: begin
                    act_s     = ACT_SQUASH;
                    pc_write  = 1'b1;
                    id_bubble = 1'b1;
                end
                default: begin
                    act_s     = ACT_ADVANCE;
                    pc_write  = 1'b1;
                    id_bubble = 1'b0;
                end
            endcase
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= {PC_W{1'b0}};
        end else begin
            case (act_s)
                ACT_ADVANCE: begin
                    id_valid <= if_valid;
                    id_inst  <= if_valid ? if_inst : NOP_INST;
                    id_pc    <= if_pc;
                end
                ACT_SQUASH: begin
                    id_valid <= 1'b0;
                    id_inst  <= NOP_INST;
                    id_pc    <= if_pc;
                end
                default: begin
                    id_valid <= id_valid;
                    id_inst  <= id_inst;
                    id_pc    <= id_pc;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((act_s == ACT_STALL) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (ex_redirect && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed vector bench for id_stage_ctrl; a second narrow-counter instance
// exercises counter saturation.
module tb_id_stage_ctrl;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADD  = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] ADDI = 32'h00128413; // addi x8,x5,1
    localparam logic [31:0] LUI  = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
    localparam logic [31:0] SW   = 32'h0054A023; // sw   x5,0(x9)

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [8:0]  if_pc;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        ext_stall;

    logic        id_valid, pc_write, id_bubble;
    logic [31:0] id_inst;
    logic [8:0]  id_pc;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_id_valid, s_pc_write, s_id_bubble;
    logic [31:0] s_id_inst;
    logic [8:0]  s_id_pc;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_vec;
    int n_fail;

    id_stage_ctrl #(.PC_W(9), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .pc_write(pc_write),
        .id_bubble(id_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_stage_ctrl #(.PC_W(9), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .id_valid(s_id_valid), .id_inst(s_id_inst), .id_pc(s_id_pc), .pc_write(s_pc_write),
        .id_bubble(s_id_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifv;
        logic [31:0] inst;
        logic [8:0]  pc;
        logic        exv;
        logic        exm;
        logic [4:0]  rd;
        logic        redir;
        logic        stl;
        logic        e_pw;
        logic        e_bub;
        logic        e_idv;
        logic [31:0] e_inst;
        logic [8:0]  e_pc;
        logic        chk_pc;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(
        input logic ifv, input logic [31:0] inst, input logic [8:0] pc,
        input logic exv, input logic exm, input logic [4:0] rd,
        input logic redir, input logic stl,
        input logic e_pw, input logic e_bub, input logic e_idv,
        input logic [31:0] e_inst, input logic [8:0] e_pc, input logic chk_pc,
        input logic [31:0] e_sc, input logic [31:0] e_fc);
        vec_t v;
        v.ifv = ifv; v.inst = inst; v.pc = pc; v.exv = exv; v.exm = exm; v.rd = rd;
        v.redir = redir; v.stl = stl; v.e_pw = e_pw; v.e_bub = e_bub; v.e_idv = e_idv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.chk_pc = chk_pc; v.e_sc = e_sc; v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ifv, input logic [31:0] inst, input logic [8:0] pc,
                          input logic exv, input logic exm, input logic [4:0] rd,
                          input logic redir, input logic stl);
        if_valid = ifv; if_inst = inst; if_pc = pc;
        ex_valid = exv; ex_mem_read = exm; ex_rd = rd;
        ex_redirect = redir; ext_stall = stl;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".idv"}, 64'(id_valid), 64'd0);
        chk({tag, ".inst"}, 64'(id_inst), 64'(NOP));
        chk({tag, ".pc"}, 64'(id_pc), 64'd0);
        chk({tag, ".sc"}, 64'(stall_cnt), 64'd0);
        chk({tag, ".fc"}, 64'(flush_cnt), 64'd0);
        chk({tag, ".pw"}, 64'(pc_write), 64'd1);
        chk({tag, ".bub"}, 64'(id_bubble), 64'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        set_in(1'b0, NOP, 9'h000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        //              ifv  inst  pc      exv   exm   rd     rdr   stl  | pw    bub   idv   inst  pc      chk   sc      fc
        vecs[0]  = mk(1'b1, ADD,  9'h010, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADD,  9'h010, 1'b1, 32'd0, 32'd0);
        vecs[1]  = mk(1'b1, ADDI, 9'h014, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ADD,  9'h010, 1'b1, 32'd1, 32'd0);
        vecs[2]  = mk(1'b1, ADDI, 9'h014, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADDI, 9'h014, 1'b1, 32'd1, 32'd0);
        vecs[3]  = mk(1'b1, LUI,  9'h018, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LUI,  9'h018, 1'b1, 32'd1, 32'd0);
        vecs[4]  = mk(1'b1, SW,   9'h01c, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SW,   9'h01c, 1'b1, 32'd1, 32'd0);
        vecs[5]  = mk(1'b1, ADD,  9'h020, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SW,   9'h01c, 1'b1, 32'd2, 32'd0);
        vecs[6]  = mk(1'b1, ADD,  9'h020, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADD,  9'h020, 1'b1, 32'd2, 32'd0);
        vecs[7]  = mk(1'b1, ADD,  9'h024, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADD,  9'h024, 1'b1, 32'd2, 32'd0);
        vecs[8]  = mk(1'b1, ADD,  9'h028, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADD,  9'h028, 1'b1, 32'd2, 32'd0);
        vecs[9]  = mk(1'b0, ADD,  9'h02c, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP,  9'h02c, 1'b1, 32'd2, 32'd0);
        vecs[10] = mk(1'b1, ADD,  9'h030, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd1);
        vecs[11] = mk(1'b1, ADD,  9'h034, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd1);
        vecs[12] = mk(1'b1, ADDI, 9'h038, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADDI, 9'h038, 1'b1, 32'd2, 32'd1);
        vecs[13] = mk(1'b1, ADD,  9'h03c, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd2);
        vecs[14] = mk(1'b1, ADD,  9'h03c, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd3);
        vecs[15] = mk(1'b1, ADD,  9'h03c, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd3);
        vecs[16] = mk(1'b1, ADD,  9'h03c, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd3);
        vecs[17] = mk(1'b1, ADD,  9'h03c, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd2, 32'd3);
        vecs[18] = mk(1'b1, ADD,  9'h040, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ADD,  9'h040, 1'b1, 32'd2, 32'd3);
        vecs[19] = mk(1'b1, SW,   9'h044, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ADD,  9'h040, 1'b1, 32'd3, 32'd3);
        vecs[20] = mk(1'b1, SW,   9'h044, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  9'h040, 1'b1, 32'd3, 32'd3);
        vecs[21] = mk(1'b1, SW,   9'h044, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  9'h040, 1'b1, 32'd3, 32'd3);
        vecs[22] = mk(1'b1, SW,   9'h044, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, SW,   9'h044, 1'b1, 32'd3, 32'd3);
        vecs[23] = mk(1'b1, ADD,  9'h048, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, SW,   9'h044, 1'b1, 32'd3, 32'd3);
        vecs[24] = mk(1'b1, ADD,  9'h048, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SW,   9'h044, 1'b1, 32'd4, 32'd3);
        vecs[25] = mk(1'b1, ADD,  9'h048, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd4, 32'd4);
        vecs[26] = mk(1'b1, ADD,  9'h04c, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,  9'h000, 1'b0, 32'd4, 32'd4);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        // Table-driven main sequence.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            set_in(vecs[i].ifv, vecs[i].inst, vecs[i].pc, vecs[i].exv, vecs[i].exm,
                   vecs[i].rd, vecs[i].redir, vecs[i].stl);
            #1;
            chk($sformatf("v%0d.pw", i), 64'(pc_write), 64'(vecs[i].e_pw));
            chk($sformatf("v%0d.bub", i), 64'(id_bubble), 64'(vecs[i].e_bub));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.idv", i), 64'(id_valid), 64'(vecs[i].e_idv));
            chk($sformatf("v%0d.inst", i), 64'(id_inst), 64'(vecs[i].e_inst));
            if (vecs[i].chk_pc) begin
                chk($sformatf("v%0d.pc", i), 64'(id_pc), 64'(vecs[i].e_pc));
            end
            chk($sformatf("v%0d.sc", i), 64'(stall_cnt), 64'(vecs[i].e_sc));
            chk($sformatf("v%0d.fc", i), 64'(flush_cnt), 64'(vecs[i].e_fc));
        end
        chk("sat.fc_table", 64'(s_flush_cnt), 64'd3);
        chk("sat.sc_table", 64'(s_stall_cnt), 64'd3);

        // Fifth stall, then reset asserted mid-stall.
        @(negedge clk);
        set_in(1'b1, ADD, 9'h050, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, ADDI, 9'h054, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid.sc5", 64'(stall_cnt), 64'd5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("mid_rst");
        @(negedge clk);
        reset = 1'b0;

        // Repeated hazards: main counts on, narrow counter saturates at 3.
        set_in(1'b1, ADD, 9'h060, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("hz%0d.pw", k), 64'(pc_write), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hz%0d.sc", k), 64'(stall_cnt), 64'(k));
            chk($sformatf("hz%0d.ssc", k), 64'(s_stall_cnt), 64'((k > 3) ? 3 : k));
            @(negedge clk);
            #1;
            chk($sformatf("hz%0d.adv", k), 64'(pc_write), 64'd1);
            @(posedge clk);
        end

        // Back-to-back redirects: flush counter per cycle, narrow one saturates.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            set_in(1'b1, ADD, 9'h070, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
            #1;
            chk($sformatf("rd%0d.bub", k), 64'(id_bubble), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("rd%0d.fc", k), 64'(flush_cnt), 64'(k));
            chk($sformatf("rd%0d.sfc", k), 64'(s_flush_cnt), 64'((k > 3) ? 3 : k));
        end
        @(negedge clk);
        set_in(1'b0, NOP, 9'h000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
